// File: rtl/ctrl_unit.sv
// ctrl_unit: multicycle MIPS-style control FSM (Moore outputs decoded from state)
// Ports:
//   clk, reset (async, active-high)   - clock and reset; reset forces RESET state
//   OPCODE[5:0], FUNCT[5:0], ZERO     - instruction fields and ULA zero flag
//   PC_w, MEM_w, IR_w, RB_w, AB_w,
//   MEM_DATA_REG_w                    - register / memory write enables
//   M_WREG, IorD, MEM_to_REG, ALUSrcA - datapath mux selects
//   ALUSrcB[1:0], ULA_op[2:0],
//   PC_src[1:0]                       - ULA operand/op and PC source selects
//   state_out[3:0]                    - current state, for debug
//   trap                              - TRAP state flag (only with CTRL_BADOP_TRAP_EN)
// Build option: define CTRL_BADOP_TRAP_EN to trap on unknown opcodes.
module ctrl_unit (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] OPCODE,
   input  logic [5:0] FUNCT,
   input  logic       ZERO,
   output logic       PC_w,
   output logic       MEM_w,
   output logic       IR_w,
   output logic       RB_w,
   output logic       AB_w,
   output logic       MEM_DATA_REG_w,
   output logic       M_WREG,
   output logic       IorD,
   output logic       MEM_to_REG,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ULA_op,
   output logic [1:0] PC_src,
   output logic [3:0] state_out
`ifdef CTRL_BADOP_TRAP_EN
   ,
   output logic       trap
`endif
);
   localparam logic [3:0] S_RESET    = 4'd0;
   localparam logic [3:0] S_FETCH    = 4'd1;
   localparam logic [3:0] S_IR_LOAD  = 4'd2;
   localparam logic [3:0] S_DECODE   = 4'd3;
   localparam logic [3:0] S_R_WB     = 4'd4;
   localparam logic [3:0] S_ADDI_WB  = 4'd5;
   localparam logic [3:0] S_LW_ADDR  = 4'd6;
   localparam logic [3:0] S_LW_MDR   = 4'd7;
   localparam logic [3:0] S_LW_WB    = 4'd8;
   localparam logic [3:0] S_SW       = 4'd9;
   localparam logic [3:0] S_BEQ_CMP  = 4'd10;
   localparam logic [3:0] S_BEQ_TAKE = 4'd11;
   localparam logic [3:0] S_JUMP     = 4'd12;
`ifdef CTRL_BADOP_TRAP_EN
   localparam logic [3:0] S_TRAP     = 4'd13;
   localparam logic [3:0] S_BADOP    = S_TRAP;
`else
   // unknown opcodes retire as a no-op; PC was already advanced in IR_LOAD
   localparam logic [3:0] S_BADOP    = S_FETCH;
`endif

   logic [3:0] state, nxt;
   logic [2:0] r_op;

   always_ff @(posedge clk or posedge reset)
      if (reset) state <= S_RESET;
      else state <= nxt;

   always_comb begin
      nxt = S_FETCH;
      case (state)
         S_RESET:   nxt = S_FETCH;
         S_FETCH:   nxt = S_IR_LOAD;
         S_IR_LOAD: nxt = S_DECODE;
         S_DECODE:  nxt = OPCODE == 6'h00 ? S_R_WB :
                          OPCODE == 6'h08 ? S_ADDI_WB :
                          OPCODE == 6'h23 ? S_LW_ADDR :
                          OPCODE == 6'h2B ? S_SW :
                          OPCODE == 6'h04 ? S_BEQ_CMP :
                          OPCODE == 6'h02 ? S_JUMP : S_BADOP;
         S_LW_ADDR: nxt = S_LW_MDR;
         S_LW_MDR:  nxt = S_LW_WB;
         S_BEQ_CMP: nxt = ZERO ? S_BEQ_TAKE : S_FETCH;
         default:   nxt = S_FETCH;
      endcase
   end

   // zero means an unsupported FUNCT: R_WB then suppresses the bank write
   assign r_op = FUNCT == 6'h20 ? 3'b001 :
                 FUNCT == 6'h22 ? 3'b010 :
                 FUNCT == 6'h24 ? 3'b011 :
                 FUNCT == 6'h26 ? 3'b110 : 3'b000;

   always_comb begin
      PC_w = 1'b0;
      MEM_w = 1'b0;
      IR_w = 1'b0;
      RB_w = 1'b0;
      AB_w = 1'b0;
      MEM_DATA_REG_w = 1'b0;
      M_WREG = 1'b0;
      IorD = 1'b0;
      MEM_to_REG = 1'b0;
      ALUSrcA = 1'b0;
      ALUSrcB = 2'b00;
      ULA_op = 3'b000;
      PC_src = 2'b00;
      case (state)
         S_IR_LOAD: begin
            IR_w = 1'b1;
            PC_w = 1'b1;
            ALUSrcB = 2'b01;
            ULA_op = 3'b001;
         end
         S_DECODE: AB_w = 1'b1;
         S_R_WB: begin
            ALUSrcA = 1'b1;
            M_WREG = 1'b1;
            ULA_op = r_op;
            RB_w = r_op != 3'b000;
         end
         S_ADDI_WB: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            ULA_op = 3'b001;
            RB_w = 1'b1;
         end
         S_LW_ADDR, S_LW_MDR: begin
            IorD = 1'b1;
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            ULA_op = 3'b001;
            MEM_DATA_REG_w = state == S_LW_MDR;
         end
         S_LW_WB: begin
            MEM_to_REG = 1'b1;
            RB_w = 1'b1;
         end
         S_SW: begin
            IorD = 1'b1;
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            ULA_op = 3'b001;
            MEM_w = 1'b1;
         end
         S_BEQ_CMP: begin
            ALUSrcA = 1'b1;
            ULA_op = 3'b010;
         end
         S_BEQ_TAKE: begin
            ALUSrcB = 2'b11;
            ULA_op = 3'b001;
            PC_w = 1'b1;
         end
         S_JUMP: begin
            PC_src = 2'b01;
            PC_w = 1'b1;
         end
`ifdef CTRL_BADOP_TRAP_EN
         S_TRAP: begin
            PC_src = 2'b10;
            PC_w = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   assign state_out = state;
`ifdef CTRL_BADOP_TRAP_EN
   assign trap = state == S_TRAP;
`endif
endmodule

// File: tb/tb_ctrl_unit.sv
// tb_ctrl_unit: randomized scoreboard bench for ctrl_unit
module tb_ctrl_unit;
   logic clk = 1'b0, reset = 1'b1, ZERO = 1'b0;
   logic [5:0] OPCODE = '0, FUNCT = '0;
   logic PC_w, MEM_w, IR_w, RB_w, AB_w, MEM_DATA_REG_w, M_WREG, IorD, MEM_to_REG, ALUSrcA;
   logic [1:0] ALUSrcB, PC_src;
   logic [2:0] ULA_op;
   logic [3:0] state_out;
   logic trap_s;
   logic [21:0] got;
   logic [21:0] q[$];
   int total = 0, bad = 0, pushed = 0;

   localparam logic [9:0] PCW = 10'h200, MEMW = 10'h100, IRW = 10'h080, RBW = 10'h040,
                          ABW = 10'h020, MDRW = 10'h010, MWREG = 10'h008, IORD = 10'h004,
                          M2R = 10'h002, SRCA = 10'h001;

`ifdef CTRL_BADOP_TRAP_EN
   logic trap;
   assign trap_s = trap;
`else
   assign trap_s = 1'b0;
`endif

   ctrl_unit dut (
      .clk(clk), .reset(reset), .OPCODE(OPCODE), .FUNCT(FUNCT), .ZERO(ZERO),
      .PC_w(PC_w), .MEM_w(MEM_w), .IR_w(IR_w), .RB_w(RB_w), .AB_w(AB_w),
      .MEM_DATA_REG_w(MEM_DATA_REG_w), .M_WREG(M_WREG), .IorD(IorD),
      .MEM_to_REG(MEM_to_REG), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ULA_op(ULA_op), .PC_src(PC_src), .state_out(state_out)
`ifdef CTRL_BADOP_TRAP_EN
      , .trap(trap)
`endif
   );

   always #5 clk = ~clk;

   assign got = {state_out, PC_w, MEM_w, IR_w, RB_w, AB_w, MEM_DATA_REG_w, M_WREG,
                 IorD, MEM_to_REG, ALUSrcA, ALUSrcB, ULA_op, PC_src, trap_s};

   function automatic logic [21:0] mk(input logic [3:0] st, input logic [9:0] en,
                                      input logic [1:0] b, input logic [2:0] op,
                                      input logic [1:0] ps, input logic tr);
      return {st, en, b, op, ps, tr};
   endfunction

   function automatic bit known(input logic [5:0] op);
      return op == 6'h00 || op == 6'h08 || op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h02;
   endfunction

   // monitor: every cycle the DUT presents one state/output word
   always @(negedge clk) begin
      logic [21:0] e;
      if (q.size() > 0) begin
         e = q.pop_front();
         total++;
         if (got !== e) begin
            bad++;
            $display("FAIL cycle%0d: got state=%0d outs=%h, want state=%0d outs=%h",
                     total, got[21:18], got[17:0], e[21:18], e[17:0]);
         end
      end
   end

   // expected cycle-by-cycle behaviour of one instruction; cut>0 truncates it
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z, input int cut);
      logic [21:0] lst[$];
      logic [2:0] a;
      int n;
      OPCODE = op;
      FUNCT = fn;
      ZERO = z;
      lst.push_back(mk(1, 0, 2'b00, 3'b000, 2'b00, 0));
      lst.push_back(mk(2, PCW | IRW, 2'b01, 3'b001, 2'b00, 0));
      lst.push_back(mk(3, ABW, 2'b00, 3'b000, 2'b00, 0));
      case (op)
         6'h00: begin
            case (fn)
               6'h20: a = 3'b001;
               6'h22: a = 3'b010;
               6'h24: a = 3'b011;
               6'h26: a = 3'b110;
               default: a = 3'b000;
            endcase
            lst.push_back(mk(4, (a != 0 ? RBW : 10'h0) | MWREG | SRCA, 2'b00, a, 2'b00, 0));
         end
         6'h08: lst.push_back(mk(5, RBW | SRCA, 2'b10, 3'b001, 2'b00, 0));
         6'h23: begin
            lst.push_back(mk(6, IORD | SRCA, 2'b10, 3'b001, 2'b00, 0));
            lst.push_back(mk(7, IORD | SRCA | MDRW, 2'b10, 3'b001, 2'b00, 0));
            lst.push_back(mk(8, M2R | RBW, 2'b00, 3'b000, 2'b00, 0));
         end
         6'h2B: lst.push_back(mk(9, IORD | SRCA | MEMW, 2'b10, 3'b001, 2'b00, 0));
         6'h04: begin
            lst.push_back(mk(10, SRCA, 2'b00, 3'b010, 2'b00, 0));
            if (z) lst.push_back(mk(11, PCW, 2'b11, 3'b001, 2'b00, 0));
         end
         6'h02: lst.push_back(mk(12, PCW, 2'b00, 3'b000, 2'b01, 0));
         default: begin
`ifdef CTRL_BADOP_TRAP_EN
            lst.push_back(mk(13, PCW, 2'b00, 3'b000, 2'b10, 1));
`endif
         end
      endcase
      n = (cut > 0 && cut < lst.size()) ? cut : lst.size();
      for (int i = 0; i < n; i++) q.push_back(lst[i]);
      pushed += n;
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic reset_seq();
      reset = 1'b1;
      q.push_back(mk(0, 0, 2'b00, 3'b000, 2'b00, 0));
      @(posedge clk);
      #2;
      q.push_back(mk(0, 0, 2'b00, 3'b000, 2'b00, 0));
      reset = 1'b0;
      @(posedge clk);
      #2;
   endtask

   initial begin
      logic [5:0] op, fn;
      logic [5:0] ops[6] = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02};
      logic [5:0] fns[4] = '{6'h20, 6'h22, 6'h24, 6'h26};
      repeat (2) @(posedge clk);
      #2;
      reset_seq();
      run_instr(6'h00, 6'h20, 1'b0, 0);
      run_instr(6'h23, 6'h00, 1'b0, 0);
      run_instr(6'h04, 6'h00, 1'b1, 0);
      run_instr(6'h04, 6'h00, 1'b0, 0);
      run_instr(6'h2B, 6'h11, 1'b1, 0);
      run_instr(6'h3F, 6'h00, 1'b0, 0);
      run_instr(6'h02, 6'h00, 1'b0, 0);
      run_instr(6'h08, 6'h00, 1'b0, 0);
      run_instr(6'h00, 6'h3A, 1'b0, 0);
      // reset arriving while LW_MDR is the current state
      run_instr(6'h23, 6'h00, 1'b0, 4);
      reset_seq();
      for (int k = 0; k < 150; k++) begin
         if ($urandom_range(0, 6) == 0) begin
            do op = 6'($urandom); while (known(op));
         end else op = ops[$urandom_range(0, 5)];
         fn = $urandom_range(0, 4) == 0 ? 6'($urandom) : fns[$urandom_range(0, 3)];
         run_instr(op, fn, 1'($urandom), 0);
         if ($urandom_range(0, 30) == 0) begin
            run_instr(6'h23, fn, 1'b0, $urandom_range(1, 5));
            reset_seq();
         end
      end
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain: pending=%0d want=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
